// File: rtl/mskaes_128bits_rnd_gen_if.sv
// rtl/mskaes_128bits_rnd_gen_if.sv - seed and randomness handshake bundle for the masked-AES randomness generator
interface mskaes_128bits_rnd_gen_if #(
  parameter int RND0 = 34,
  parameter int RND1 = 36,
  parameter int RND2 = 34
);
  logic [63:0]          seed;
  logic                 seed_valid;
  logic                 seed_ready;
  logic                 rnd_req;
  logic                 rnd_valid;
  logic [16*RND0-1:0]   rnd_bus0w;
  logic [16*RND1-1:0]   rnd_bus1w;
  logic [16*RND2-1:0]   rnd_bus2w;

  // Consumer / seed source side
  modport master (
    output seed, seed_valid, rnd_req,
    input  seed_ready, rnd_valid, rnd_bus0w, rnd_bus1w, rnd_bus2w
  );

  // Generator side
  modport slave (
    input  seed, seed_valid, rnd_req,
    output seed_ready, rnd_valid, rnd_bus0w, rnd_bus1w, rnd_bus2w
  );
endinterface

// File: rtl/mskaes_128bits_rnd_gen.sv
// rtl/mskaes_128bits_rnd_gen.sv - xorshift64 lane array feeding the masked S-box randomness buses
module mskaes_128bits_rnd_gen #(
  parameter int RND0 = 34,
  parameter int RND1 = 36,
  parameter int RND2 = 34,
  parameter int WARM = 4
) (
  input  logic                      clk,
  input  logic                      nrst,
  mskaes_128bits_rnd_gen_if.slave   bus
);
  localparam int          W    = 16 * (RND0 + RND1 + RND2);
  localparam int          L    = (W + 63) / 64;
  localparam int          B0   = 16 * RND0;
  localparam int          B1   = 16 * RND1;
  localparam int          B2   = 16 * RND2;
  localparam logic [63:0] GOLD = 64'h9E3779B97F4A7C15;

  typedef enum logic [1:0] {IDLE, WARMUP, RUN} state_t;

  state_t          r_state, w_state_nx;
  logic [7:0]      r_cnt, w_cnt_nx;
  logic            r_seed_ready;
  logic            r_rnd_valid;
  logic [63:0]     r_lane [L];
  logic [64*L-1:0] w_cat;
  logic            w_seed_acc;
  logic            w_consume;
  logic            w_load;
  logic            w_step;

  // One xorshift64 step (13, 7, 17)
  function automatic logic [63:0] f_step(input logic [63:0] x);
    logic [63:0] v;
    v = x ^ (x << 13);
    v = v ^ (v >> 7);
    v = v ^ (v << 17);
    return v;
  endfunction

  // Lane seeding: spread the seed with golden-ratio multiples; an all-zero lane would lock up xorshift
  function automatic logic [63:0] f_seed_lane(input logic [63:0] s, input int unsigned idx);
    logic [63:0] v;
    v = s ^ (64'(idx) * GOLD);
    return (v == 64'd0) ? GOLD : v;
  endfunction

  assign w_seed_acc = bus.seed_valid && r_seed_ready;
  assign w_consume  = bus.rnd_req && r_rnd_valid;

  // Next-state, counter and lane-update decisions; a seed accept outranks a consume
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_load     = 1'b0;
    w_step     = 1'b0;
    if (w_seed_acc) begin
      w_load     = 1'b1;
      w_cnt_nx   = 8'(WARM);
      w_state_nx = (WARM > 0) ? WARMUP : RUN;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nx = IDLE;
        end
        WARMUP: begin
          w_step = 1'b1;
          if (r_cnt != 8'd0) begin
            w_cnt_nx = r_cnt - 8'd1;
          end
          if (r_cnt <= 8'd1) begin
            w_state_nx = RUN;
          end
        end
        RUN: begin
          w_step = w_consume;
        end
        default: begin
          w_state_nx = IDLE;
        end
      endcase
    end
  end

  // State, counter and registered handshake outputs
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state      <= IDLE;
      r_cnt        <= 8'd0;
      r_seed_ready <= 1'b1;
      r_rnd_valid  <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_cnt        <= w_cnt_nx;
      r_seed_ready <= (w_state_nx != WARMUP);
      r_rnd_valid  <= (w_state_nx == RUN);
    end
  end

  // Generator lanes: load on seed accept, otherwise step when asked, otherwise hold
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < L; i++) begin
        r_lane[i] <= 64'd0;
      end
    end else if (w_load) begin
      for (int i = 0; i < L; i++) begin
        r_lane[i] <= f_seed_lane(bus.seed, i);
      end
    end else if (w_step) begin
      for (int i = 0; i < L; i++) begin
        r_lane[i] <= f_step(r_lane[i]);
      end
    end
  end

  for (genvar g = 0; g < L; g++) begin : g_cat
    assign w_cat[64*g +: 64] = r_lane[g];
  end

  assign bus.seed_ready = r_seed_ready;
  assign bus.rnd_valid  = r_rnd_valid;
  assign bus.rnd_bus0w  = w_cat[B0-1:0];
  assign bus.rnd_bus1w  = w_cat[B0+B1-1:B0];
  assign bus.rnd_bus2w  = w_cat[B0+B1+B2-1:B0+B1];
endmodule

// File: tb/tb_mskaes_128bits_rnd_gen.sv
// tb/tb_mskaes_128bits_rnd_gen.sv - scoreboard bench for the masked-AES randomness generator
module tb_mskaes_128bits_rnd_gen;
  localparam int          W    = 16 * (34 + 36 + 34);
  localparam int          L    = (W + 63) / 64;
  localparam logic [63:0] GOLD = 64'h9E3779B97F4A7C15;

  logic clk;
  logic nrst;
  int   total;
  int   bad;

  logic [W-1:0] sb_q [$];
  logic [63:0]  m_lane [L];

  mskaes_128bits_rnd_gen_if if0 ();
  mskaes_128bits_rnd_gen_if if1 ();

  mskaes_128bits_rnd_gen #(.WARM(0)) u_dut0 (.clk(clk), .nrst(nrst), .bus(if0));
  mskaes_128bits_rnd_gen #(.WARM(1)) u_dut1 (.clk(clk), .nrst(nrst), .bus(if1));

  wire [W-1:0] cat0 = {if0.rnd_bus2w, if0.rnd_bus1w, if0.rnd_bus0w};
  wire [W-1:0] cat1 = {if1.rnd_bus2w, if1.rnd_bus1w, if1.rnd_bus0w};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ref_step(input logic [63:0] x);
    logic [63:0] v;
    v = x ^ (x << 13);
    v = v ^ (v >> 7);
    v = v ^ (v << 17);
    return v;
  endfunction

  task automatic m_init(input logic [63:0] s);
    logic [63:0] v;
    for (int i = 0; i < L; i++) begin
      v = s ^ (64'(i) * GOLD);
      m_lane[i] = (v == 64'd0) ? GOLD : v;
    end
  endtask

  task automatic m_step();
    for (int i = 0; i < L; i++) m_lane[i] = ref_step(m_lane[i]);
  endtask

  function automatic logic [W-1:0] m_cat();
    logic [W-1:0] c;
    for (int i = 0; i < L; i++) c[64*i +: 64] = m_lane[i];
    return c;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic chk_bus(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    int idx;
    idx = -1;
    total++;
    if (act !== exp) begin
      bad++;
      for (int i = L - 1; i >= 0; i--) if (act[64*i +: 64] !== exp[64*i +: 64]) idx = i;
      $display("FAIL %s lane=%0d act=%h exp=%h", name, idx, act[64*idx +: 64], exp[64*idx +: 64]);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every consumed value on dut0 is popped and compared against the scoreboard
  always @(negedge clk) begin
    if (nrst && if0.rnd_valid && if0.rnd_req) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_underflow act=%h exp=<none>", cat0[63:0]);
      end else begin
        chk_bus("sb_consume", cat0, sb_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic any_zero;
    logic [63:0] s;
    total = 0;
    bad   = 0;
    nrst  = 1'b0;
    if0.seed = '0; if0.seed_valid = 1'b0; if0.rnd_req = 1'b0;
    if1.seed = '0; if1.seed_valid = 1'b0; if1.rnd_req = 1'b0;
    repeat (3) @(posedge clk);
    #1 nrst = 1'b1;

    // No seed: idle outputs for 20 cycles whatever rnd_req does
    for (int c = 0; c < 20; c++) begin
      if0.rnd_req = c[0];
      if1.rnd_req = ~c[0];
      cyc();
      chk("idle_valid", {63'd0, if0.rnd_valid | if1.rnd_valid}, 64'd0);
      chk("idle_ready", {63'd0, if0.seed_ready & if1.seed_ready}, 64'd1);
      chk_bus("idle_bus0", cat0, '0);
      chk_bus("idle_bus1", cat1, '0);
    end
    if0.rnd_req = 1'b0;
    if1.rnd_req = 1'b0;

    // seed=1 on both: WARM=0 is valid at once, WARM=1 drops seed_ready for one cycle
    chk("pre_ready1", {63'd0, if1.seed_ready}, 64'd1);
    if0.seed = 64'd1; if0.seed_valid = 1'b1;
    if1.seed = 64'd1; if1.seed_valid = 1'b1;
    cyc();
    if0.seed_valid = 1'b0;
    if1.seed_valid = 1'b0;
    chk("w0_valid", {63'd0, if0.rnd_valid}, 64'd1);
    chk("w0_lane0", if0.rnd_bus0w[63:0], 64'h1);
    chk("w0_lane1", if0.rnd_bus0w[127:64], 64'h9E3779B97F4A7C14);
    chk("w1_ready_warm", {63'd0, if1.seed_ready}, 64'd0);
    chk("w1_valid_warm", {63'd0, if1.rnd_valid}, 64'd0);
    m_init(64'd1);
    sb_q.push_back(m_cat());
    m_step();
    if0.rnd_req = 1'b1;
    cyc();
    if0.rnd_req = 1'b0;
    chk("w0_step_lane0", if0.rnd_bus0w[63:0], 64'h40822041);
    chk_bus("w0_step_bus", cat0, m_cat());
    chk("w1_ready_run", {63'd0, if1.seed_ready}, 64'd1);
    chk("w1_valid_run", {63'd0, if1.rnd_valid}, 64'd1);
    chk("w1_lane0", if1.rnd_bus0w[63:0], 64'h40822041);

    // Hold with rnd_req low, then five back-to-back consumes
    for (int c = 0; c < 10; c++) begin
      cyc();
      chk_bus("hold_bus", cat0, m_cat());
    end
    for (int c = 0; c < 5; c++) begin
      sb_q.push_back(m_cat());
      m_step();
      if0.rnd_req = 1'b1;
      cyc();
    end
    if0.rnd_req = 1'b0;
    chk_bus("burst_end_bus", cat0, m_cat());

    // seed=0 and seed=GOLD: zero lanes get replaced
    if0.seed = 64'd0; if0.seed_valid = 1'b1;
    cyc();
    if0.seed_valid = 1'b0;
    chk("z_lane0", if0.rnd_bus0w[63:0], GOLD);
    chk("z_lane1", if0.rnd_bus0w[127:64], GOLD);
    m_init(64'd0);
    chk_bus("z_bus", cat0, m_cat());
    any_zero = 1'b0;
    for (int c = 0; c < 8; c++) begin
      sb_q.push_back(m_cat());
      m_step();
      if0.rnd_req = 1'b1;
      cyc();
      for (int i = 0; i < L; i++) if (cat0[64*i +: 64] == 64'd0) any_zero = 1'b1;
    end
    if0.rnd_req = 1'b0;
    chk("z_no_zero_lane", {63'd0, any_zero}, 64'd0);
    if0.seed = GOLD; if0.seed_valid = 1'b1;
    cyc();
    if0.seed_valid = 1'b0;
    chk("g_lane0", if0.rnd_bus0w[63:0], GOLD);
    chk("g_lane1", if0.rnd_bus0w[127:64], GOLD);

    // Seed accept coincident with a consume: seed wins, no step
    m_init(GOLD);
    sb_q.push_back(m_cat());
    s = 64'h0123456789ABCDEF;
    if0.seed = s; if0.seed_valid = 1'b1; if0.rnd_req = 1'b1;
    if1.seed = s; if1.seed_valid = 1'b1; if1.rnd_req = 1'b1;
    cyc();
    if0.seed_valid = 1'b0; if0.rnd_req = 1'b0;
    if1.seed_valid = 1'b0; if1.rnd_req = 1'b0;
    m_init(s);
    chk("co_w0_valid", {63'd0, if0.rnd_valid}, 64'd1);
    chk_bus("co_w0_bus", cat0, m_cat());
    chk("co_w1_ready", {63'd0, if1.seed_ready}, 64'd0);
    chk("co_w1_valid", {63'd0, if1.rnd_valid}, 64'd0);
    chk_bus("co_w1_bus", cat1, m_cat());

    // Asynchronous reset pulse while dut1 is in WARMUP
    #2 nrst = 1'b0;
    #1;
    chk("rst_ready", {63'd0, if0.seed_ready & if1.seed_ready}, 64'd1);
    chk("rst_valid", {63'd0, if0.rnd_valid | if1.rnd_valid}, 64'd0);
    chk_bus("rst_bus0", cat0, '0);
    chk_bus("rst_bus1", cat1, '0);
    #2 nrst = 1'b1;
    if0.rnd_req = 1'b1;
    if1.rnd_req = 1'b1;
    for (int c = 0; c < 5; c++) begin
      cyc();
      chk("post_rst_valid", {63'd0, if0.rnd_valid | if1.rnd_valid}, 64'd0);
      chk("post_rst_ready", {63'd0, if0.seed_ready & if1.seed_ready}, 64'd1);
      chk_bus("post_rst_bus1", cat1, '0);
    end
    if0.rnd_req = 1'b0;
    if1.rnd_req = 1'b0;
    cyc();

    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mskaes_128bits_rnd_gen.md
MSKAES_128BITS_RND_GEN -- requirements
Module: MSKaes_128bits_rnd_gen

Interface
REQ-001 SHALL have parameter RND0, default 34: fresh-randomness bits per S-box on bus 0.
REQ-002 SHALL have parameter RND1, default 36: fresh-randomness bits per S-box on bus 1.
REQ-003 SHALL have parameter RND2, default 34: fresh-randomness bits per S-box on bus 2.
REQ-004 SHALL have parameter WARM, default 4: number of warm-up steps after a seed load, range 0..255.
REQ-005 SHALL have port clk, input, 1: single clock, rising edge.
REQ-006 SHALL have port nrst, input, 1: reset, asynchronous and active-low.
REQ-007 SHALL have port seed, input, 64: seed value.
REQ-008 SHALL have port seed_valid, input, 1: seed offered.
REQ-009 SHALL have port seed_ready, output, 1: seed can be accepted.
REQ-010 SHALL have port rnd_req, input, 1: consumer takes the current randomness.
REQ-011 SHALL have port rnd_valid, output, 1: the buses hold fresh, unconsumed randomness.
REQ-012 SHALL have port rnd_bus0w, output, 16*RND0: randomness for the 16-S-box layer, bus 0.
REQ-013 SHALL have port rnd_bus1w, output, 16*RND1: randomness for the 16-S-box layer, bus 1.
REQ-014 SHALL have port rnd_bus2w, output, 16*RND2: randomness for the 16-S-box layer, bus 2.

Function
REQ-015 SHALL hold the generator state as L = ceil(W/64) 64-bit lanes.
- W = 16*(RND0+RND1+RND2).
- With the default parameters, W = 1664 and L = 26.
REQ-016 SHALL form the concatenation {lane L-1, ..., lane 0}, truncate it to its W LSBs, and drive the buses from it.
- rnd_bus0w is the LSBs.
- rnd_bus1w is next.
- rnd_bus2w is the MSBs.
- All buses are driven directly from registers, with no combinational path from any input.
REQ-017 SHALL apply the following step to each lane x in sequence, all lanes in parallel in one cycle:
- x ^= x<<13
- x ^= x>>7
- x ^= x<<17
- All operations are mod 2^64.
REQ-018 SHALL, on seed load, set lane i = seed XOR (i * 0x9E3779B97F4A7C15 mod 2^64).
- Any lane that evaluates to 0 is replaced by 0x9E3779B97F4A7C15.
REQ-019 SHALL implement FSM states IDLE, WARMUP and RUN.
REQ-020 SHALL drive seed_ready = 1 in IDLE and RUN, and 0 in WARMUP.
REQ-021 SHALL treat a cycle with seed_valid && seed_ready as a seed accept.
- The seed is loaded on that edge.
- The warm-up counter is set to WARM.
- The next state is WARMUP if WARM > 0, otherwise RUN.
REQ-022 SHALL, in WARMUP, step all lanes every cycle and decrement the counter.
- The transition to RUN occurs on the edge where the counter goes 1 -> 0.
- Exactly WARM steps occur.
REQ-023 SHALL drive rnd_valid = 1 only in RUN, and 0 in IDLE and WARMUP.
REQ-024 SHALL, in RUN, step all lanes on the edge following any cycle with rnd_req && rnd_valid.
- Otherwise the lanes hold.
- Back-to-back rnd_req SHALL yield a new value every cycle.
REQ-025 SHALL ignore rnd_req when rnd_valid = 0.
REQ-026 SHALL give priority to the seed load when a seed accept and rnd_req && rnd_valid occur in the same RUN cycle.
- The current value counts as consumed.
- No step is applied.
- The seed is loaded and WARMUP is entered per REQ-021.
REQ-027 SHALL ignore seed_valid while in WARMUP, because seed_ready = 0.
REQ-028 SHALL never present the same bus value twice under rnd_valid without an intervening step or seed load.

Reset
REQ-029 SHALL, on nrst low, asynchronously set:
- state = IDLE
- all lanes = 0, so all rnd_bus*w = 0
- warm-up counter = 0
- rnd_valid = 0
- seed_ready = 1
REQ-030 SHALL leave IDLE only by a seed accept.
- Reset during WARMUP or RUN abandons the operation.
- A new seed is then required before rnd_valid can rise.

Verification
REQ-031 SHALL cover: reset released, no seed -> rnd_valid = 0, seed_ready = 1, all buses 0 for 20 cycles, regardless of rnd_req.
REQ-032 SHALL cover: WARM=0, seed=1 accepted ->
- next cycle rnd_valid = 1
- rnd_bus0w[63:0] = 0x1
- rnd_bus0w[127:64] = 0x9E3779B97F4A7C14
- after one rnd_req cycle, rnd_bus0w[63:0] = 0x40822041
REQ-033 SHALL cover: WARM=1, seed=1 ->
- seed_ready = 0 for exactly 1 cycle
- then rnd_valid = 1 with rnd_bus0w[63:0] = 0x40822041
REQ-034 SHALL cover: seed=0 ->
- lane 0 = 0x9E3779B97F4A7C15
- lane 1 = 0x9E3779B97F4A7C15
- no lane is ever 0
REQ-035 SHALL cover: RUN with rnd_req held low for 10 cycles -> buses stable; rnd_req high for 5 cycles -> 5 distinct successive values matching a reference model.
REQ-036 SHALL cover: seed accept coincident with rnd_req in RUN, plus nrst pulsed mid-WARMUP ->
- seed wins and WARMUP is entered
- after the reset pulse, IDLE with all outputs at reset values
